// File: rtl/redirect_unit_if.sv
// Purpose: EX-to-PC redirect bus. Carries resolved control-flow info from EX
//          and the redirect / RAS status outputs back toward the PC stage.
// Ports (modports):
//   master - drives ex_* resolution fields, observes redirect and RAS status
//   slave  - consumes ex_* fields, drives br_*/ret_*/flush_o and RAS status
interface redirect_unit_if #(
  parameter int unsigned PTR_W = 3
);
  logic               ex_valid;
  logic               ex_stall;
  logic [31:0]        ex_pc;
  logic               ex_is_br;
  logic               ex_br_taken;
  logic               ex_is_jump;
  logic               ex_is_call;
  logic               ex_is_ret;
  logic [31:0]        ex_tgt;
  logic [31:0]        ex_ret_tgt;

  logic               br_ctrl;
  logic [31:0]        br_addr;
  logic               ret_ctrl;
  logic [31:0]        ret_pc;
  logic               flush_o;
  logic               ras_empty;
  logic [PTR_W:0]     ras_cnt;
  logic [15:0]        ras_mismatch_cnt;

  modport master (
    output ex_valid, ex_stall, ex_pc, ex_is_br, ex_br_taken, ex_is_jump,
           ex_is_call, ex_is_ret, ex_tgt, ex_ret_tgt,
    input  br_ctrl, br_addr, ret_ctrl, ret_pc, flush_o, ras_empty, ras_cnt,
           ras_mismatch_cnt
  );

  modport slave (
    input  ex_valid, ex_stall, ex_pc, ex_is_br, ex_br_taken, ex_is_jump,
           ex_is_call, ex_is_ret, ex_tgt, ex_ret_tgt,
    output br_ctrl, br_addr, ret_ctrl, ret_pc, flush_o, ras_empty, ras_cnt,
           ras_mismatch_cnt
  );
endinterface

// File: rtl/redirect_unit.sv
// Purpose: Control-flow resolution between EX and the PC register. Turns
//          resolved branches/jumps into br_ctrl/br_addr pulses, returns into
//          ret_ctrl/ret_pc pulses predicted by a circular return-address
//          stack, and ignores wrong-path EX instructions for SHADOW cycles
//          after every redirect.
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - redirect_unit_if.slave: ex_* inputs, redirect and RAS outputs
module redirect_unit #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PTR_W     = 3,
  parameter int unsigned SHADOW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  redirect_unit_if.slave bus
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SH_W  = $clog2(SHADOW + 2);

  logic [31:0]      ras [RAS_DEPTH];
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SH_W-1:0]  shadow, shadow_nxt;
  logic [15:0]      mis, mis_nxt;

  logic             br_nxt, ret_nxt;
  logic [31:0]      br_addr_nxt, ret_pc_nxt;

  logic             ras_we;
  logic [PTR_W-1:0] ras_widx;
  logic [31:0]      ras_wdata;

  logic             accept;
  logic             empty;
  logic [PTR_W-1:0] top_idx;
  logic [31:0]      top;

  // ptr names the next free slot, so the top entry sits one below it
  assign top_idx = ptr - PTR_W'(1);
  assign top     = ras[top_idx];
  assign empty   = (cnt == '0);
  assign accept  = bus.ex_valid & ~bus.ex_stall & (shadow == '0);

  // Next-state and redirect decision; priority is branch, ret, then jump
  always_comb begin
    br_nxt      = 1'b0;
    ret_nxt     = 1'b0;
    br_addr_nxt = bus.br_addr;
    ret_pc_nxt  = bus.ret_pc;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    mis_nxt     = mis;
    shadow_nxt  = (shadow != '0) ? shadow - SH_W'(1) : shadow;
    ras_we      = 1'b0;
    ras_widx    = ptr;
    ras_wdata   = bus.ex_pc + 32'd4;

    if (accept) begin
      if (bus.ex_is_br) begin
        if (bus.ex_br_taken) begin
          br_nxt      = 1'b1;
          br_addr_nxt = bus.ex_tgt;
          shadow_nxt  = SH_W'(SHADOW);
        end
      end else if (bus.ex_is_ret) begin
        ret_nxt    = 1'b1;
        shadow_nxt = SH_W'(SHADOW);
        if (empty) begin
          ret_pc_nxt = bus.ex_ret_tgt;
          // Coroutine swap on an empty stack degenerates to a plain push
          if (bus.ex_is_call) begin
            ras_we  = 1'b1;
            ptr_nxt = ptr + PTR_W'(1);
            cnt_nxt = CNT_W'(1);
          end
        end else begin
          ret_pc_nxt = top;
          if ((top != bus.ex_ret_tgt) && (mis != 16'hFFFF)) begin
            mis_nxt = mis + 16'd1;
          end
          if (bus.ex_is_call) begin
            ras_we   = 1'b1;
            ras_widx = top_idx;
          end else begin
            ptr_nxt = top_idx;
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
      end else if (bus.ex_is_jump) begin
        br_nxt      = 1'b1;
        br_addr_nxt = bus.ex_tgt;
        shadow_nxt  = SH_W'(SHADOW);
        // Full stack overwrites the oldest entry; count saturates
        if (bus.ex_is_call) begin
          ras_we  = 1'b1;
          ptr_nxt = ptr + PTR_W'(1);
          if (cnt != CNT_W'(RAS_DEPTH)) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr                  <= '0;
      cnt                  <= '0;
      shadow               <= '0;
      mis                  <= '0;
      bus.br_ctrl          <= 1'b0;
      bus.br_addr          <= '0;
      bus.ret_ctrl         <= 1'b0;
      bus.ret_pc           <= '0;
      bus.flush_o          <= 1'b0;
      bus.ras_empty        <= 1'b1;
      bus.ras_cnt          <= '0;
      bus.ras_mismatch_cnt <= '0;
    end else begin
      ptr                  <= ptr_nxt;
      cnt                  <= cnt_nxt;
      shadow               <= shadow_nxt;
      mis                  <= mis_nxt;
      bus.br_ctrl          <= br_nxt;
      bus.br_addr          <= br_addr_nxt;
      bus.ret_ctrl         <= ret_nxt;
      bus.ret_pc           <= ret_pc_nxt;
      bus.flush_o          <= br_nxt | ret_nxt;
      bus.ras_empty        <= (cnt_nxt == '0);
      bus.ras_cnt          <= cnt_nxt;
      bus.ras_mismatch_cnt <= mis_nxt;
    end
  end

  // Stack storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras[ras_widx] <= ras_wdata;
    end
  end

endmodule

// File: tb/tb_redirect_unit.sv
// Purpose: Directed self-checking bench for redirect_unit. Each task drives
//          one scenario and checks the registered outputs 1 time unit after
//          the relevant rising edge against hand-computed values.
module tb_redirect_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  redirect_unit_if #(.PTR_W(3)) bus ();

  redirect_unit #(.RAS_DEPTH(8), .PTR_W(3), .SHADOW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.ex_valid    = 1'b0;
    bus.ex_stall    = 1'b0;
    bus.ex_pc       = '0;
    bus.ex_is_br    = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.ex_is_jump  = 1'b0;
    bus.ex_is_call  = 1'b0;
    bus.ex_is_ret   = 1'b0;
    bus.ex_tgt      = '0;
    bus.ex_ret_tgt  = '0;
  endtask

  // Present one instruction across a rising edge; returns 1 unit after it
  task automatic issue(input logic [31:0] pc, input logic br, input logic taken,
                       input logic jump, input logic call, input logic ret,
                       input logic [31:0] tgt, input logic [31:0] rtgt);
    bus.ex_valid    = 1'b1;
    bus.ex_pc       = pc;
    bus.ex_is_br    = br;
    bus.ex_br_taken = taken;
    bus.ex_is_jump  = jump;
    bus.ex_is_call  = call;
    bus.ex_is_ret   = ret;
    bus.ex_tgt      = tgt;
    bus.ex_ret_tgt  = rtgt;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL reset_br_ctrl got %b exp 0", bus.br_ctrl); end
    checks++; if (bus.ret_ctrl !== 1'b0) begin errors++; $display("FAIL reset_ret_ctrl got %b exp 0", bus.ret_ctrl); end
    checks++; if (bus.br_addr !== 32'h0) begin errors++; $display("FAIL reset_br_addr got %h exp 0", bus.br_addr); end
    checks++; if (bus.ret_pc !== 32'h0) begin errors++; $display("FAIL reset_ret_pc got %h exp 0", bus.ret_pc); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush_o); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL reset_ras_empty got %b exp 1", bus.ras_empty); end
    checks++; if (bus.ras_cnt !== 4'd0) begin errors++; $display("FAIL reset_ras_cnt got %0d exp 0", bus.ras_cnt); end
    checks++; if (bus.ras_mismatch_cnt !== 16'd0) begin errors++; $display("FAIL reset_mismatch got %0d exp 0", bus.ras_mismatch_cnt); end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_branch();
    issue(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    checks++; if (bus.br_ctrl !== 1'b1) begin errors++; $display("FAIL br_taken_ctrl got %b exp 1", bus.br_ctrl); end
    checks++; if (bus.br_addr !== 32'h100) begin errors++; $display("FAIL br_taken_addr got %h exp 100", bus.br_addr); end
    checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL br_taken_flush got %b exp 1", bus.flush_o); end
    checks++; if (bus.ret_ctrl !== 1'b0) begin errors++; $display("FAIL br_taken_ret_ctrl got %b exp 0", bus.ret_ctrl); end
    idle(1);
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL br_pulse_end got %b exp 0", bus.br_ctrl); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL br_flush_end got %b exp 0", bus.flush_o); end
    idle(1);
    // Not-taken branch: no redirect
    issue(32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h180, 32'h0);
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b exp 0", bus.br_ctrl); end
    checks++; if (bus.br_addr !== 32'h100) begin errors++; $display("FAIL br_not_taken_addr got %h exp 100", bus.br_addr); end
    // Stalled taken branch: not consumed
    bus.ex_valid = 1'b1; bus.ex_stall = 1'b1; bus.ex_is_br = 1'b1;
    bus.ex_br_taken = 1'b1; bus.ex_tgt = 32'h240;
    @(posedge clk); #1; clear_inputs();
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL stall_br_ctrl got %b exp 0", bus.br_ctrl); end
  endtask

  task automatic test_call_ret();
    issue(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    checks++; if (bus.br_addr !== 32'h200) begin errors++; $display("FAIL call_br_addr got %h exp 200", bus.br_addr); end
    checks++; if (bus.br_ctrl !== 1'b1) begin errors++; $display("FAIL call_br_ctrl got %b exp 1", bus.br_ctrl); end
    checks++; if (bus.ras_cnt !== 4'd1) begin errors++; $display("FAIL call_ras_cnt got %0d exp 1", bus.ras_cnt); end
    checks++; if (bus.ras_empty !== 1'b0) begin errors++; $display("FAIL call_ras_empty got %b exp 0", bus.ras_empty); end
    idle(3);
    issue(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h44);
    checks++; if (bus.ret_ctrl !== 1'b1) begin errors++; $display("FAIL ret_ctrl got %b exp 1", bus.ret_ctrl); end
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL ret_br_ctrl got %b exp 0", bus.br_ctrl); end
    checks++; if (bus.ret_pc !== 32'h44) begin errors++; $display("FAIL ret_pc got %h exp 44", bus.ret_pc); end
    checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL ret_flush got %b exp 1", bus.flush_o); end
    checks++; if (bus.ras_cnt !== 4'd0) begin errors++; $display("FAIL ret_ras_cnt got %0d exp 0", bus.ras_cnt); end
    checks++; if (bus.ras_mismatch_cnt !== 16'd0) begin errors++; $display("FAIL ret_mismatch got %0d exp 0", bus.ras_mismatch_cnt); end
    idle(2);
  endtask

  task automatic test_empty_ret();
    issue(32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h80);
    checks++; if (bus.ret_ctrl !== 1'b1) begin errors++; $display("FAIL empty_ret_ctrl got %b exp 1", bus.ret_ctrl); end
    checks++; if (bus.ret_pc !== 32'h80) begin errors++; $display("FAIL empty_ret_pc got %h exp 80", bus.ret_pc); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL empty_ret_empty got %b exp 1", bus.ras_empty); end
    checks++; if (bus.ras_cnt !== 4'd0) begin errors++; $display("FAIL empty_ret_cnt got %0d exp 0", bus.ras_cnt); end
    idle(2);
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pc;
    for (int i = 0; i < 9; i++) begin
      issue(32'(i * 16), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
      idle(2);
    end
    checks++; if (bus.ras_cnt !== 4'd8) begin errors++; $display("FAIL ovf_ras_cnt got %0d exp 8", bus.ras_cnt); end
    for (int j = 0; j < 8; j++) begin
      exp_pc = 32'h84 - 32'(j * 16);
      issue(32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, exp_pc);
      checks++; if (bus.ret_pc !== exp_pc) begin errors++; $display("FAIL ovf_ret_pc[%0d] got %h exp %h", j, bus.ret_pc, exp_pc); end
      idle(2);
    end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_ras_empty got %b exp 1", bus.ras_empty); end
    checks++; if (bus.ras_cnt !== 4'd0) begin errors++; $display("FAIL ovf_ras_cnt_end got %0d exp 0", bus.ras_cnt); end
    checks++; if (bus.ras_mismatch_cnt !== 16'd0) begin errors++; $display("FAIL ovf_mismatch got %0d exp 0", bus.ras_mismatch_cnt); end
  endtask

  task automatic test_shadow();
    issue(32'h500, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    checks++; if (bus.br_addr !== 32'h500) begin errors++; $display("FAIL shadow_jump_addr got %h exp 500", bus.br_addr); end
    issue(32'h504, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0);
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL shadow_br_ctrl got %b exp 0", bus.br_ctrl); end
    checks++; if (bus.br_addr !== 32'h500) begin errors++; $display("FAIL shadow_br_addr got %h exp 500", bus.br_addr); end
    idle(1);
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL shadow_late_br got %b exp 0", bus.br_ctrl); end
    // Shadow expired: next branch is accepted
    issue(32'h508, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h680, 32'h0);
    checks++; if (bus.br_addr !== 32'h680) begin errors++; $display("FAIL post_shadow_addr got %h exp 680", bus.br_addr); end
    idle(2);
  endtask

  task automatic test_mismatch();
    issue(32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
    idle(2);
    issue(32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h50);
    checks++; if (bus.ret_pc !== 32'h44) begin errors++; $display("FAIL mis_ret_pc got %h exp 44", bus.ret_pc); end
    checks++; if (bus.ras_mismatch_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt got %0d exp 1", bus.ras_mismatch_cnt); end
    checks++; if (bus.ras_cnt !== 4'd0) begin errors++; $display("FAIL mis_ras_cnt got %0d exp 0", bus.ras_cnt); end
    idle(2);
  endtask

  task automatic test_coroutine();
    issue(32'h60, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h90);
    checks++; if (bus.ret_ctrl !== 1'b1) begin errors++; $display("FAIL co_empty_ret_ctrl got %b exp 1", bus.ret_ctrl); end
    checks++; if (bus.ret_pc !== 32'h90) begin errors++; $display("FAIL co_empty_ret_pc got %h exp 90", bus.ret_pc); end
    checks++; if (bus.ras_cnt !== 4'd1) begin errors++; $display("FAIL co_empty_cnt got %0d exp 1", bus.ras_cnt); end
    idle(2);
    issue(32'h70, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h64);
    checks++; if (bus.ret_pc !== 32'h64) begin errors++; $display("FAIL co_swap_ret_pc got %h exp 64", bus.ret_pc); end
    checks++; if (bus.ras_cnt !== 4'd1) begin errors++; $display("FAIL co_swap_cnt got %0d exp 1", bus.ras_cnt); end
    checks++; if (bus.ras_mismatch_cnt !== 16'd1) begin errors++; $display("FAIL co_swap_mis got %0d exp 1", bus.ras_mismatch_cnt); end
    idle(2);
    issue(32'h90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h74);
    checks++; if (bus.ret_pc !== 32'h74) begin errors++; $display("FAIL co_pop_ret_pc got %h exp 74", bus.ret_pc); end
    checks++; if (bus.ras_cnt !== 4'd0) begin errors++; $display("FAIL co_pop_cnt got %0d exp 0", bus.ras_cnt); end
    idle(2);
  endtask

  task automatic test_reset_mid();
    issue(32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
    checks++; if (bus.br_ctrl !== 1'b1) begin errors++; $display("FAIL mid_pre_br_ctrl got %b exp 1", bus.br_ctrl); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.br_ctrl !== 1'b0) begin errors++; $display("FAIL mid_br_ctrl got %b exp 0", bus.br_ctrl); end
    checks++; if (bus.br_addr !== 32'h0) begin errors++; $display("FAIL mid_br_addr got %h exp 0", bus.br_addr); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL mid_flush got %b exp 0", bus.flush_o); end
    checks++; if (bus.ret_pc !== 32'h0) begin errors++; $display("FAIL mid_ret_pc got %h exp 0", bus.ret_pc); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL mid_ras_empty got %b exp 1", bus.ras_empty); end
    checks++; if (bus.ras_cnt !== 4'd0) begin errors++; $display("FAIL mid_ras_cnt got %0d exp 0", bus.ras_cnt); end
    checks++; if (bus.ras_mismatch_cnt !== 16'd0) begin errors++; $display("FAIL mid_mismatch got %0d exp 0", bus.ras_mismatch_cnt); end
    @(negedge clk);
    rst = 1'b0;
    // Shadow was cleared by reset, so this branch is accepted immediately
    issue(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h800, 32'h0);
    checks++; if (bus.br_ctrl !== 1'b1) begin errors++; $display("FAIL post_rst_br_ctrl got %b exp 1", bus.br_ctrl); end
    checks++; if (bus.br_addr !== 32'h800) begin errors++; $display("FAIL post_rst_br_addr got %h exp 800", bus.br_addr); end
    idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_branch();
    test_call_ret();
    test_empty_ret();
    test_overflow();
    test_shadow();
    test_mismatch();
    test_coroutine();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/redirect_unit.md
Name: redirect_unit

Overview:
Control-flow resolution block between the execute stage and the PC register. It consumes resolved branch, jump, call and return information from EX and drives the PC's redirect inputs: br_ctrl/br_addr for taken branches and jumps, ret_ctrl/ret_pc for returns. Return targets come from an internal return-address stack (RAS). After every redirect it suppresses the wrong-path instructions still in flight.

Parameters:
RAS_DEPTH, 8, number of RAS entries; power of two, at least 2
PTR_W, 3, log2(RAS_DEPTH)
SHADOW, 2, cycles after a redirect during which ex_valid is ignored

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  EX holds a valid instruction this cycle
ex_stall  in  1  EX stalled; the instruction is not consumed
ex_pc  in  32  PC of the EX instruction
ex_is_br  in  1  conditional branch
ex_br_taken  in  1  branch condition resolved taken
ex_is_jump  in  1  jal/jalr that is not a return
ex_is_call  in  1  jump whose rd is x1 or x5 (push)
ex_is_ret  in  1  jalr with rs1 x1/x5 and rd x0 (pop)
ex_tgt  in  32  computed target of the branch or jump
ex_ret_tgt  in  32  architecturally computed return target
br_ctrl  out  1  one-cycle pulse: load br_addr into the PC
br_addr  out  32  redirect address
ret_ctrl  out  1  one-cycle pulse: load ret_pc into the PC
ret_pc  out  32  return address
flush_o  out  1  squash IF/ID; asserted with br_ctrl or ret_ctrl
ras_empty  out  1  RAS holds no entries
ras_cnt  out  PTR_W+1  number of valid entries
ras_mismatch_cnt  out  16  saturating count of RAS predictions that differed from ex_ret_tgt

Behaviour:
- Reset (rst=1, async): br_ctrl=0, br_addr=0, ret_ctrl=0, ret_pc=0, flush_o=0, ras_cnt=0, ras_empty=1, ras_mismatch_cnt=0, top pointer=0, shadow counter=0. RAS contents are don't-care.
- An instruction is accepted when ex_valid=1, ex_stall=0 and the shadow counter is 0. Stalled, invalid or shadowed instructions have no effect on any state or output.
- All outputs are registered: a redirect is visible exactly 1 cycle after the accepting edge. br_ctrl and ret_ctrl are single-cycle pulses and are never asserted together.
- Taken branch (ex_is_br & ex_br_taken): br_ctrl=1, br_addr=ex_tgt. A not-taken branch produces no output.
- Jump (ex_is_jump): br_ctrl=1, br_addr=ex_tgt. If ex_is_call is also set, push ex_pc+4 (modulo 2^32).
- Return (ex_is_ret):
  - RAS non-empty: ret_ctrl=1 and ret_pc=top entry; then pop.
  - RAS empty: ret_ctrl=1 and ret_pc=ex_ret_tgt; no pop; ras_cnt stays 0.
  - If the RAS was non-empty and its top differs from ex_ret_tgt, ras_mismatch_cnt increments, saturating at 0xFFFF. The RAS value is still used; correction belongs to the commit stage.
- Call and return together (ex_is_ret & ex_is_call, coroutine swap): ret_pc=top (or ex_ret_tgt if empty), then the top entry is overwritten with ex_pc+4. ras_cnt is unchanged, or becomes 1 if the RAS was empty.
- Push when ras_cnt=RAS_DEPTH: circular overwrite of the oldest entry. The pointer wraps modulo RAS_DEPTH and ras_cnt stays at RAS_DEPTH.
- Pop: the pointer decrements modulo RAS_DEPTH and ras_cnt decrements. Underflow is impossible because empty-pop is suppressed.
- Shadow: any redirect loads the shadow counter with SHADOW, then it decrements once per cycle, including stall cycles. An accepted instruction that arrives while the counter is non-zero is ignored completely: no push, no pop, no output.
- flush_o equals br_ctrl | ret_ctrl, registered in the same cycle.
- Reset mid-operation: all state clears immediately, regardless of any pending pulse or shadow.
- Input flags are treated as mutually exclusive except the call+ret pair. If they overlap otherwise, priority is branch, then ret, then jump.

Test Plan:
- Reset, then accept a taken branch with ex_tgt=0x100 -> one cycle later br_ctrl=1, br_addr=0x100, flush_o=1; next cycle br_ctrl=0.
- Call at ex_pc=0x40 with ex_tgt=0x200, wait 3 cycles, then ret with ex_ret_tgt=0x44 -> ret_ctrl=1, ret_pc=0x44, ras_cnt goes 1 then 0, mismatch count stays 0.
- Ret on an empty RAS with ex_ret_tgt=0x80 -> ret_pc=0x80, ras_empty stays 1, ras_cnt=0.
- 9 calls at ex_pc=0x0,0x10,…,0x80 (RAS_DEPTH=8, each spaced past the shadow) -> ras_cnt=8; 8 rets return 0x84,0x74,…,0x14; ras_empty=1 afterwards.
- Jump, then a valid branch one cycle later (inside the shadow) -> only the jump redirect appears; the branch is ignored.
- Push 0x44, then ret with ex_ret_tgt=0x50 -> ret_pc=0x44 and ras_mismatch_cnt=1. Assert rst mid-sequence -> all outputs 0 and ras_empty=1 immediately.
